// File: rtl/flight_uart_tx.sv
// rtl/flight_uart_tx.sv - frame RAM to 8N1 UART downlink serializer with CRC-16/CCITT-FALSE trailer
module flight_uart_tx #(
    parameter int CLK_DIV = 434,
    parameter int BYTES   = 192,
    parameter int RD_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame,
    output logic [6:0]  rd_FLIGHT,
    input  logic [31:0] FLIGHT_out,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LOAD, S_SHIFT, S_CRC_HI, S_CRC_LO, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        frame_d;
    logic        fall;
    logic        accept;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [9:0]  byte_idx;
    logic [9:0]  byte_idx_inc;
    logic [7:0]  lat_cnt;
    logic [15:0] crc;
    logic [31:0] word_q;
    logic [7:0]  cur_byte;
    logic        serializing;
    logic        bit_end;
    logic        byte_end;
    logic        lat_end;
    logic        crc_in;
    logic        crc_fb;

    assign fall         = frame_d & ~frame;
    assign byte_idx_inc = byte_idx + 10'd1;
    assign bit_end      = (baud_cnt == 16'(CLK_DIV - 1));
    assign byte_end     = bit_end && (bit_cnt == 4'd9);
    assign lat_end      = (lat_cnt == 8'(RD_LAT - 1));
    assign serializing  = (state_q == S_SHIFT) || (state_q == S_CRC_HI) || (state_q == S_CRC_LO);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);

    always_comb begin
        cur_byte = word_q[7:0];
        case (state_q)
            S_CRC_HI: cur_byte = crc[15:8];
            S_CRC_LO: cur_byte = crc[7:0];
            default: begin
                case (byte_idx[1:0])
                    2'd0:    cur_byte = word_q[7:0];
                    2'd1:    cur_byte = word_q[15:8];
                    2'd2:    cur_byte = word_q[23:16];
                    default: cur_byte = word_q[31:24];
                endcase
            end
        endcase
    end

    // tx is decoded from registered state so an asynchronous reset forces it high at once
    always_comb begin
        tx = 1'b1;
        if (serializing) begin
            if (bit_cnt == 4'd0)
                tx = 1'b0;
            else if (bit_cnt != 4'd9)
                tx = cur_byte[3'(bit_cnt - 4'd1)];
        end
    end

    // Payload bits fold MSB-first during the first 8 clocks of the start bit
    assign crc_in = cur_byte[3'(3'd7 - baud_cnt[2:0])];
    assign crc_fb = crc[15] ^ crc_in;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_ADDR;
                    accept  = 1'b1;
                end
            end
            S_ADDR:  if (lat_end) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (byte_end) begin
                    if (byte_idx_inc == 10'(BYTES))
                        state_d = S_CRC_HI;
                    else if (byte_idx_inc[1:0] == 2'd0)
                        state_d = S_ADDR;
                end
            end
            S_CRC_HI: if (byte_end) state_d = S_CRC_LO;
            S_CRC_LO: if (byte_end) state_d = S_DONE;
            S_DONE: begin
                if (fall) begin
                    state_d = S_ADDR;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_d   <= 1'b0;
            overrun   <= 1'b0;
            rd_FLIGHT <= 7'd0;
            byte_idx  <= 10'd0;
            lat_cnt   <= 8'd0;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            crc       <= 16'hFFFF;
            word_q    <= 32'd0;
        end else begin
            frame_d <= frame;
            overrun <= fall && busy;
            if (accept) begin
                rd_FLIGHT <= 7'd0;
                byte_idx  <= 10'd0;
                lat_cnt   <= 8'd0;
                crc       <= 16'hFFFF;
            end
            case (state_q)
                S_ADDR: lat_cnt <= lat_end ? 8'd0 : lat_cnt + 8'd1;
                S_LOAD: begin
                    word_q   <= FLIGHT_out;
                    baud_cnt <= 16'd0;
                    bit_cnt  <= 4'd0;
                end
                S_SHIFT, S_CRC_HI, S_CRC_LO: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                    if (state_q == S_SHIFT && bit_cnt == 4'd0 && baud_cnt < 16'd8)
                        crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
                    if (state_q == S_SHIFT && byte_end) begin
                        byte_idx <= byte_idx_inc;
                        if (state_d == S_ADDR) begin
                            rd_FLIGHT <= byte_idx_inc[8:2];
                            lat_cnt   <= 8'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
